// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, opcodes, datapath selects.
// Pure definitions plus a branch-resolution helper; no storage, no flow control.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRWB, S_LUI
  } state_t;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMM       = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // neg is the raw sign of A-B, so blt/bge are wrong on signed overflow by design.
  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      F3_BEQ:  return z;
      F3_BNE:  return !z;
      F3_BLT:  return n;
      F3_BGE:  return !n;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU op class plus funct3/funct7[5]/op[5] to ALUControl.
// Purely combinational, no flow control.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opb5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // only R-type (op[5]=1) may turn funct3=000 into sub; addi never does
          3'b000:  alucontrol = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared-ALU multicycle RV32I datapath, 3-5 cycles per instruction.
// Outputs combinational from state (BRANCH PCWrite also from flags); never stalls.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite
);

  state_t state, state_next;
  aluop_t aluop;
  logic   pcw, mw, irw, rw;
  logic   unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    pcw        = 1'b0;
    mw         = 1'b0;
    irw        = 1'b0;
    rw         = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_REG;
    aluop      = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        irw = 1'b1; pcw = 1'b1;
        ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BR:        state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          OP_JALR:      state_next = S_JALR;
          OP_LUI:       state_next = S_LUI;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REG; ALUSrcB = SRCB_IMM;
        state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD:  begin AdrSrc = 1'b1; state_next = S_MEMWB; end
      S_MEMWB:    begin ResultSrc = RES_DATA; rw = 1'b1; end
      S_MEMWRITE: begin AdrSrc = 1'b1; mw = 1'b1; end
      S_EXECR: begin
        ALUSrcA = SRCA_REG; ALUSrcB = SRCB_REG; aluop = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_REG; ALUSrcB = SRCB_IMM; aluop = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: rw = 1'b1;
      S_BRANCH: begin
        ALUSrcA = SRCA_REG; ALUSrcB = SRCB_REG; aluop = ALUOP_SUB;
        pcw = branch_taken(funct3, zero, neg);
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; pcw = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = SRCA_REG; ALUSrcB = SRCB_IMM; ResultSrc = RES_ALURESULT; pcw = 1'b1;
        state_next = S_JALRWB;
      end
      S_JALRWB: begin
        ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT; rw = 1'b1;
      end
      S_LUI:   begin ResultSrc = RES_IMM; rw = 1'b1; end
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_LW, OP_I, OP_JALR: ImmSrc = IMM_I;
      OP_SW:                ImmSrc = IMM_S;
      OP_BR:                ImmSrc = IMM_B;
      OP_JAL:               ImmSrc = IMM_J;
      OP_LUI:               ImmSrc = IMM_U;
      default:              ImmSrc = IMM_I;
    endcase
  end

  // Reset kills all write enables at once, so an abandoned instruction leaves no trace.
  assign PCWrite  = pcw & ~rst;
  assign MemWrite = mw  & ~rst;
  assign IRWrite  = irw & ~rst;
  assign RegWrite = rw  & ~rst;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7[5]),
    .opb5       (op[5]),
    .alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction step model checked every cycle,
// plus directed literal checks on selected cycles.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] imm;
    logic [2:0] alu;
    logic       rw;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, neg;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;

  int   checks = 0;
  int   errors = 0;
  int   step = 0;
  ctl_t act, expc;
  ctl_t snap [0:4];

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .neg(neg), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite)
  );

  always #5 clk = ~clk;

  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, ALUControl, RegWrite};

  function automatic int cpi(input logic [6:0] o);
    case (o)
      7'b0000011:                                     return 5;
      7'b0100011, 7'b0110011, 7'b0010011,
      7'b1101111, 7'b1100111:                         return 4;
      7'b1100011, 7'b0110111:                         return 3;
      default:                                        return 2;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  // What the instruction's arithmetic step must compute.
  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3,
                                        input logic [6:0] f7);
    case (f3)
      3'b000:  return (o == 7'b0110011 && f7 == 7'b0100000) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic ctl_t model(input logic r, input logic [6:0] o, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic z, input logic n,
                                 input int s);
    ctl_t c;
    c = '0;
    c.imm = imm_of(o);
    if (r || s == 0) begin
      c.irw = !r; c.pcw = !r; c.srcb = 2'b10; c.res = 2'b10;
    end else if (s == 1) begin
      c.srca = 2'b01; c.srcb = 2'b01;
    end else begin
      case (o)
        7'b0000011, 7'b0100011: begin
          if (s == 2) begin c.srca = 2'b10; c.srcb = 2'b01; end
          else if (s == 3) begin c.adr = 1'b1; c.mw = (o == 7'b0100011); end
          else begin c.res = 2'b01; c.rw = 1'b1; end
        end
        7'b0110011, 7'b0010011: begin
          if (s == 2) begin
            c.srca = 2'b10; c.srcb = (o == 7'b0110011) ? 2'b00 : 2'b01;
            c.alu = alu_of(o, f3, f7);
          end else c.rw = 1'b1;
        end
        7'b1100011: begin
          c.srca = 2'b10; c.alu = 3'b001;
          c.pcw = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && n) || (f3 == 3'd5 && !n);
        end
        7'b1101111: begin
          if (s == 2) begin c.srca = 2'b01; c.srcb = 2'b10; c.pcw = 1'b1; end
          else c.rw = 1'b1;
        end
        7'b1100111: begin
          c.res = 2'b10;
          if (s == 2) begin c.srca = 2'b10; c.srcb = 2'b01; c.pcw = 1'b1; end
          else begin c.srca = 2'b01; c.srcb = 2'b10; c.rw = 1'b1; end
        end
        7'b0110111: begin c.res = 2'b11; c.rw = 1'b1; end
        default: c = c;
      endcase
    end
    return c;
  endfunction

  // Position within the current instruction; reset snaps it back to the fetch step.
  always @(posedge clk or posedge rst) begin
    if (rst) step <= 0;
    else     step <= (step == cpi(op) - 1) ? 0 : step + 1;
  end

  always begin
    @(negedge clk);
    #2;
    expc = model(rst, op, funct3, funct7, zero, neg, step);
    checks++;
    if (act !== expc) begin
      errors++;
      $display("FAIL cycle_ctl t=%0t step=%0d op=%b actual=%h required=%h",
               $time, step, op, act, expc);
    end
  end

  task automatic chk(input string name, input logic [3:0] a, input logic [3:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask

  // Called at a negedge while in fetch; returns at the next instruction's fetch negedge.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input logic n);
    op = o; funct3 = f3; funct7 = f7; zero = z; neg = n;
    for (int k = 0; k < 5; k++) snap[k] = '0;
    for (int k = 0; k < cpi(o); k++) begin
      #3 snap[k] = act;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7 = 7'd0; zero = 1'b0; neg = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #3;
    chk("rst_write_enables", {PCWrite, MemWrite, IRWrite, RegWrite}, 4'b0000);
    chk("rst_srcb_fetch", {2'b00, ALUSrcB}, 4'b0010);
    @(negedge clk);
    rst = 1'b0;

    run_instr(7'b0000011, 3'b010, 7'd0, 1'b0, 1'b0);
    chk("lw_fetch_irwrite", {3'b000, snap[0].irw}, 4'b0001);
    chk("lw_memread_adr", {3'b000, snap[3].adr}, 4'b0001);
    chk("lw_wb_rw_res", {1'b0, snap[4].rw, snap[4].res}, 4'b0101);

    run_instr(7'b0100011, 3'b010, 7'd0, 1'b0, 1'b0);
    chk("sw_memwrite_adr", {2'b00, snap[3].mw, snap[3].adr}, 4'b0011);
    chk("sw_no_regwrite", {snap[0].rw, snap[1].rw, snap[2].rw, snap[3].rw}, 4'b0000);

    run_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0);
    chk("r_sub", {1'b0, snap[2].alu}, 4'h1);
    run_instr(7'b0110011, 3'b111, 7'b0000000, 1'b0, 1'b0);
    chk("r_and", {1'b0, snap[2].alu}, 4'h2);
    run_instr(7'b0110011, 3'b010, 7'b0000000, 1'b0, 1'b0);
    chk("r_slt", {1'b0, snap[2].alu}, 4'h5);
    run_instr(7'b0010011, 3'b000, 7'b0100000, 1'b0, 1'b0);
    chk("addi_not_sub", {1'b0, snap[2].alu}, 4'h0);
    run_instr(7'b0010011, 3'b110, 7'b0000000, 1'b0, 1'b0);
    chk("ori_or", {1'b0, snap[2].alu}, 4'h3);

    run_instr(7'b1100011, 3'b000, 7'd0, 1'b1, 1'b0);
    chk("beq_taken", {3'b000, snap[2].pcw}, 4'h1);
    run_instr(7'b1100011, 3'b001, 7'd0, 1'b1, 1'b0);
    chk("bne_not_taken", {3'b000, snap[2].pcw}, 4'h0);
    run_instr(7'b1100011, 3'b100, 7'd0, 1'b0, 1'b1);
    chk("blt_taken", {3'b000, snap[2].pcw}, 4'h1);
    run_instr(7'b1100011, 3'b101, 7'd0, 1'b0, 1'b1);
    chk("bge_not_taken", {3'b000, snap[2].pcw}, 4'h0);
    #3 chk("branch_back_to_fetch", {3'b000, IRWrite}, 4'h1);
    @(negedge clk);
    // the extra negedge wait above put us mid-DECODE; finish that unknown-op-free slot
    op = 7'b1111111;
    @(negedge clk);

    run_instr(7'b1101111, 3'b000, 7'd0, 1'b0, 1'b0);
    chk("jal_pcw_c3_rw_c4", {2'b00, snap[2].pcw, snap[3].rw}, 4'h3);
    run_instr(7'b1100111, 3'b000, 7'd0, 1'b0, 1'b0);
    chk("jalr_c3", {1'b0, snap[2].pcw, snap[2].res}, 4'h6);
    chk("jalr_rw_c4", {3'b000, snap[3].rw}, 4'h1);
    run_instr(7'b0110111, 3'b000, 7'd0, 1'b0, 1'b0);
    chk("lui_c3", {1'b0, snap[2].rw, snap[2].res}, 4'h7);

    run_instr(7'b1111111, 3'b000, 7'd0, 1'b0, 1'b0);
    chk("unk_decode_no_writes", {snap[1].pcw, snap[1].mw, snap[1].irw, snap[1].rw}, 4'h0);
    #3 chk("unk_back_to_fetch", {3'b000, IRWrite}, 4'h1);
    @(negedge clk);
    op = 7'b1111111;
    @(negedge clk);

    op = 7'b0000011; funct3 = 3'b010;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #3 chk("midrst_fetch_sel", {ALUSrcA, ALUSrcB}, 4'b0010);
    chk("midrst_no_writes", {PCWrite, MemWrite, IRWrite, RegWrite}, 4'h0);
    @(negedge clk);
    #3 chk("midrst_hold_no_writes", {PCWrite, MemWrite, IRWrite, RegWrite}, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    run_instr(7'b0100011, 3'b010, 7'd0, 1'b0, 1'b0);
    chk("after_rst_sw", {2'b00, snap[3].mw, snap[0].irw}, 4'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
